// File: rtl/led_pwm_pkg.sv
// rtl/led_pwm_pkg.sv - register map, CTRL bit indices, duty limit and fade state encoding
package led_pwm_pkg;

   localparam logic [1:0] ADDR_CTRL     = 2'd0;
   localparam logic [1:0] ADDR_PRESCALE = 2'd1;
   localparam logic [1:0] ADDR_DUTY     = 2'd2;
   localparam logic [1:0] ADDR_STATUS   = 2'd3;

   localparam int CTRL_EN     = 0;
   localparam int CTRL_FADE   = 1;
   localparam int STATUS_BUSY = 16;

   localparam logic [8:0] DUTY_MAX = 9'd256;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      DOWN = 2'd2
   } fade_state_t;

   // Targets above full scale clamp to full scale rather than wrapping.
   function automatic logic [8:0] sat_duty(input logic [31:0] value);
      return (value > 32'(DUTY_MAX)) ? DUTY_MAX : value[8:0];
   endfunction

endpackage

// File: rtl/led_pwm_timebase.sv
// rtl/led_pwm_timebase.sv - prescaler and 8-bit PWM phase counter with tick/period_end
module led_pwm_timebase #(
   parameter int PRESCALE_W = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  prescale_wr,
   output logic [7:0]            pwm_cnt,
   output logic                  tick,
   output logic                  period_end
);

   logic [PRESCALE_W-1:0] pre_cnt;
   logic                  wrap;

   // A prescale write restarts the prescaler and swallows any tick in that cycle.
   assign wrap       = (pre_cnt >= prescale);
   assign tick       = wrap && !prescale_wr;
   assign period_end = tick && (pwm_cnt == 8'hFF);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pre_cnt <= '0;
         pwm_cnt <= '0;
      end else begin
         if (prescale_wr || wrap)
            pre_cnt <= '0;
         else
            pre_cnt <= pre_cnt + PRESCALE_W'(1);
         if (tick)
            pwm_cnt <= pwm_cnt + 8'd1;
      end
   end

endmodule

// File: rtl/led_pwm_dimmer.sv
// rtl/led_pwm_dimmer.sv - masked shared-duty PWM LED driver; LED_PWM_FADE_EN adds duty fading
module led_pwm_dimmer
   import led_pwm_pkg::*;
#(
   parameter int CHANNELS   = 26,
   parameter int PRESCALE_W = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [1:0]          address,
   input  logic                chipselect,
   input  logic                write_n,
   input  logic [31:0]         writedata,
   output logic [31:0]         readdata,
   input  logic [CHANNELS-1:0] led_mask,
   output logic [CHANNELS-1:0] led_out
);

   logic                  wr;
   logic                  ctrl_en;
   logic                  ctrl_fade;
   logic [PRESCALE_W-1:0] prescale;
   logic [8:0]            target;
   logic [8:0]            cur_duty;
   logic [8:0]            cur_next;
   logic                  fade_busy;
   logic [7:0]            pwm_cnt;
   logic                  tick;
   logic                  period_end;

   assign wr = chipselect && !write_n;

   led_pwm_timebase #(.PRESCALE_W(PRESCALE_W)) u_timebase (
      .clk         (clk),
      .reset_n     (reset_n),
      .prescale    (prescale),
      .prescale_wr (wr && (address == ADDR_PRESCALE)),
      .pwm_cnt     (pwm_cnt),
      .tick        (tick),
      .period_end  (period_end)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_en  <= 1'b0;
         prescale <= '0;
         target   <= '0;
      end else if (wr) begin
         case (address)
            ADDR_CTRL:     ctrl_en  <= writedata[CTRL_EN];
            ADDR_PRESCALE: prescale <= writedata[PRESCALE_W-1:0];
            ADDR_DUTY:     target   <= sat_duty(writedata);
            default:       ;
         endcase
      end
   end

`ifdef LED_PWM_FADE_EN
   fade_state_t state, state_next;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         ctrl_fade <= 1'b0;
      else if (wr && (address == ADDR_CTRL))
         ctrl_fade <= writedata[CTRL_FADE];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Direction is re-chosen at every boundary, so a retargeted fade never overshoots.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (ctrl_fade && (target > cur_duty))
               state_next = UP;
            else if (ctrl_fade && (target < cur_duty))
               state_next = DOWN;
         end
         UP, DOWN: begin
            if (period_end) begin
               if (!ctrl_fade)
                  state_next = IDLE;
               else if (target > cur_duty)
                  state_next = (cur_duty + 9'd1 == target) ? IDLE : UP;
               else if (target < cur_duty)
                  state_next = (cur_duty - 9'd1 == target) ? IDLE : DOWN;
               else
                  state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      cur_next  = cur_duty;
      fade_busy = (state != IDLE);
      if (period_end) begin
         if (!ctrl_fade)
            cur_next = target;
         else if (state != IDLE) begin
            if (target > cur_duty)
               cur_next = cur_duty + 9'd1;
            else if (target < cur_duty)
               cur_next = cur_duty - 9'd1;
         end
      end
   end
`else
   assign ctrl_fade = 1'b0;
   assign fade_busy = 1'b0;
   assign cur_next  = period_end ? target : cur_duty;
`endif

   // Duty only moves on a period boundary so no PWM period is ever truncated.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cur_duty <= '0;
         led_out  <= '0;
      end else begin
         cur_duty <= cur_next;
         led_out  <= (ctrl_en && ({1'b0, pwm_cnt} < cur_duty)) ? led_mask : '0;
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_CTRL: begin
            readdata[CTRL_EN]   = ctrl_en;
            readdata[CTRL_FADE] = ctrl_fade;
         end
         ADDR_PRESCALE: readdata[PRESCALE_W-1:0] = prescale;
         ADDR_DUTY:     readdata[8:0] = target;
         ADDR_STATUS: begin
            readdata[8:0]       = cur_duty;
            readdata[STATUS_BUSY] = fade_busy;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_led_pwm_dimmer.sv
// tb/tb_led_pwm_dimmer.sv - scoreboard bench for led_pwm_dimmer (both LED_PWM_FADE_EN builds)
module tb_led_pwm_dimmer;
   import led_pwm_pkg::*;

   localparam logic [25:0] ALL_ON = 26'h3FFFFFF;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [25:0] led_mask;
   logic [25:0] led_out;

   always #5 clk = ~clk;

   led_pwm_dimmer #(.CHANNELS(26), .PRESCALE_W(16)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .led_mask   (led_mask),
      .led_out    (led_out)
   );

   // kind: 0 readdata, 1 led_out, 2 cycles led_out==pat over n, 3 led_out[0] high run, 4 tick, 5 pre_cnt
   typedef struct {
      int          kind;
      string       name;
      logic [31:0] val;
      logic [25:0] pat;
      int          n;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   bit   mon_busy = 1'b0;

   initial begin
      exp_t        e;
      logic [31:0] act;
      int          w;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            mon_busy = 1'b1;
            e = q.pop_front();
            act = '0;
            case (e.kind)
               0: act = readdata;
               1: act = 32'(led_out);
               2: for (int i = 0; i < e.n; i++) begin
                     if (led_out == e.pat) act++;
                     @(negedge clk);
                  end
               3: begin
                  w = 0;
                  while (led_out[0] && w < e.n) begin @(negedge clk); w++; end
                  while (!led_out[0] && w < e.n) begin @(negedge clk); w++; end
                  while (led_out[0] && act < e.n) begin act++; @(negedge clk); end
               end
               4: act = 32'(dut.u_timebase.tick);
               5: act = 32'(dut.u_timebase.pre_cnt);
               default: act = 32'hDEAD_BEEF;
            endcase
            checks++;
            if (act !== e.val) begin
               errors++;
               $display("FAIL %s: actual %0h required %0h", e.name, act, e.val);
            end
            mon_busy = 1'b0;
         end
      end
   end

   task automatic chk(input int kind, input string name, input logic [31:0] val,
                      input logic [25:0] pat, input int n);
      exp_t e;
      int   t;
      e.kind = kind; e.name = name; e.val = val; e.pat = pat; e.n = n;
      q.push_back(e);
      t = 0;
      @(posedge clk); #1;
      while ((q.size() > 0 || mon_busy) && t < 10000) begin @(posedge clk); #1; t++; end
      if (t >= 10000) begin
         checks++; errors++;
         $display("FAIL %s: monitor timeout, actual none required %0h", name, val);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      step(1);
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic rd(input logic [1:0] a, input logic [31:0] v, input string name);
      address = a;
      chk(0, name, v, '0, 0);
   endtask

   task automatic wait_status_change(input logic [8:0] prev);
      int t = 0;
      address = ADDR_STATUS;
      while (readdata[8:0] == prev && t < 400) begin step(1); t++; end
   endtask

   initial begin
      int t;
      reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
      address = '0; writedata = '0; led_mask = '0;
      step(3);
      reset_n = 1'b1;

      rd(ADDR_CTRL, 0, "reset_ctrl");
      rd(ADDR_PRESCALE, 0, "reset_prescale");
      rd(ADDR_DUTY, 0, "reset_duty");
      rd(ADDR_STATUS, 0, "reset_status");
      chk(1, "reset_led_out", 0, '0, 0);

      led_mask = ALL_ON;
      bus_write(ADDR_CTRL, 1);
      bus_write(ADDR_PRESCALE, 0);
      bus_write(ADDR_DUTY, 64);
      rd(ADDR_CTRL, 1, "ctrl_readback");
      rd(ADDR_DUTY, 64, "duty_readback");
      step(300);
      chk(2, "duty64_high_cycles", 64, ALL_ON, 256);
      chk(3, "duty64_high_run", 64, '0, 600);
      rd(ADDR_STATUS, 64, "status_duty64");

      bus_write(ADDR_DUTY, 300);
      rd(ADDR_DUTY, 256, "duty_saturate");
      led_mask = 26'h0000005;
      step(300);
      chk(2, "mask5_duty256_constant", 300, 26'h0000005, 300);
      bus_write(ADDR_DUTY, 0);
      step(300);
      chk(2, "duty0_all_off", 256, 26'h0, 256);

`ifdef LED_PWM_FADE_EN
      bus_write(ADDR_CTRL, 3);
      rd(ADDR_CTRL, 3, "ctrl_fade_readback");
      t = 0;
      while (!dut.u_timebase.period_end && t < 2000) begin step(1); t++; end
      step(1);
      bus_write(ADDR_DUTY, 4);
      step(2);
      rd(ADDR_STATUS, 32'h0001_0000, "fade_busy_rise");
      for (int k = 1; k <= 4; k++) begin
         wait_status_change(9'(k - 1));
         rd(ADDR_STATUS, ((k < 4) ? 32'h0001_0000 : 32'h0) | 32'(k), "fade_up_step");
      end
      bus_write(ADDR_DUTY, 2);
      for (int k = 3; k >= 2; k--) begin
         wait_status_change(9'(k + 1));
         rd(ADDR_STATUS, ((k == 3) ? 32'h0001_0000 : 32'h0) | 32'(k), "fade_down_step");
      end
      bus_write(ADDR_STATUS, 32'hFFFF_FFFF);
      rd(ADDR_STATUS, 2, "status_read_only");
`else
      bus_write(ADDR_CTRL, 3);
      rd(ADDR_CTRL, 1, "ctrl_fade_masked");
      bus_write(ADDR_DUTY, 4);
      step(300);
      rd(ADDR_STATUS, 4, "status_no_fade");
      bus_write(ADDR_STATUS, 32'hFFFF_FFFF);
      rd(ADDR_STATUS, 4, "status_read_only");
`endif

      bus_write(ADDR_CTRL, 1);
      bus_write(ADDR_PRESCALE, 3);
      rd(ADDR_PRESCALE, 3, "prescale_readback");
      bus_write(ADDR_DUTY, 64);
      step(1100);
      chk(3, "prescale3_high_run", 256, '0, 2100);
      chk(2, "prescale3_high_cycles", 256, 26'h0000005, 1024);

      t = 0;
      while (!dut.u_timebase.tick && t < 20) begin step(1); t++; end
      address = ADDR_PRESCALE; writedata = 3; chipselect = 1'b1; write_n = 1'b0;
      chk(4, "tick_suppressed_on_write", 0, '0, 0);
      chipselect = 1'b0; write_n = 1'b1;
      chk(5, "pre_cnt_restart", 0, '0, 0);

      bus_write(ADDR_DUTY, 256);
      step(1100);
      chk(1, "pre_reset_full_on", 32'h5, '0, 0);
      bus_write(ADDR_CTRL, 3);
      bus_write(ADDR_DUTY, 100);
      step(5);
      reset_n = 1'b0;
      chk(1, "async_reset_led_out", 0, '0, 0);
      rd(ADDR_CTRL, 0, "async_reset_ctrl");
      rd(ADDR_STATUS, 0, "async_reset_status");
      rd(ADDR_DUTY, 0, "async_reset_duty");
      step(2);
      reset_n = 1'b1;
      step(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
